// File: rtl/mtx_tx_framer_if.sv
// Output sample stream from the TX framer toward the radio TX datapath.
// The master drives data/valid/markers and the slave drives ready.
interface mtx_tx_framer_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic [2*DATA_WIDTH-1:0] o_tdata;
  logic                    o_tvalid;
  logic                    o_tready;
  logic                    o_tlast;
  logic                    o_tsof;

  modport master (output o_tdata, output o_tvalid, output o_tlast, output o_tsof,
                  input  o_tready);
  modport slave  (input  o_tdata, input  o_tvalid, input  o_tlast, input  o_tsof,
                  output o_tready);
endinterface

// File: rtl/mtx_tx_framer.sv
// Aligns the TX controller's sample stream to symbol/burst boundaries and buffers
// it in a first-word-fall-through FIFO with sof/last markers and sticky error flags.
module mtx_tx_framer #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned NSIG        = 8192,
  parameter int unsigned NSYMB       = 16,
  parameter int unsigned SIG_WIDTH   = 24,
  parameter int unsigned NSYMB_WIDTH = 16,
  parameter int unsigned FIFO_AW     = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  itx,
  input  logic [DATA_WIDTH-1:0]  qtx,
  input  logic                   tx_valid,
  input  logic                   tx_trig,
  input  logic                   err_clr,
  mtx_tx_framer_if.master        m_tx,
  output logic [NSYMB_WIDTH-1:0] symb_idx,
  output logic                   busy,
  output logic                   overflow,
  output logic                   sync_err
);
  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned PW    = FIFO_AW + 1;
  localparam int unsigned DW2   = 2 * DATA_WIDTH;
  localparam int unsigned EW    = DW2 + 2;

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state;
  logic [SIG_WIDTH-1:0] sig_cnt;
  logic [EW-1:0]        mem [DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;

  logic                   accept_c;
  logic                   start_c;
  logic                   sync_ev_c;
  logic                   last_c;
  logic                   pop_c;
  logic                   full_c;
  logic                   push_c;
  logic                   ovf_ev_c;
  logic [SIG_WIDTH-1:0]   pos_c;
  logic [NSYMB_WIDTH-1:0] sym_c;
  logic [PW-1:0]          rd_nxt_c;
  logic [PW-1:0]          wr_nxt_c;
  logic [EW-1:0]          entry_c;
  logic [EW-1:0]          head_c;

  // Framing decision, FIFO handshakes and the head entry after this edge.
  always_comb begin
    accept_c  = tx_valid && (state == RUN || tx_trig);
    start_c   = tx_valid && tx_trig && (state == IDLE || sig_cnt != '0);
    sync_ev_c = start_c && (state == RUN);
    pos_c     = start_c ? '0 : sig_cnt;
    sym_c     = start_c ? '0 : symb_idx;
    last_c    = (pos_c == SIG_WIDTH'(NSIG - 1));
    entry_c   = {start_c, last_c, itx, qtx};
    pop_c     = m_tx.o_tvalid && m_tx.o_tready;
    full_c    = ((wr_ptr - rd_ptr) == PW'(DEPTH));
    push_c    = accept_c && (!full_c || pop_c);
    ovf_ev_c  = accept_c && !push_c;
    rd_nxt_c  = pop_c  ? rd_ptr + PW'(1) : rd_ptr;
    wr_nxt_c  = push_c ? wr_ptr + PW'(1) : wr_ptr;
    // A sample written into the slot that becomes head bypasses the array.
    head_c    = (push_c && rd_nxt_c == wr_ptr) ? entry_c : mem[rd_nxt_c[FIFO_AW-1:0]];
  end

  assign busy = (state == RUN);

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr[FIFO_AW-1:0]] <= entry_c;
    end
  end

  // Framing FSM, FIFO pointers, registered output stage and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      sig_cnt       <= '0;
      symb_idx      <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      m_tx.o_tvalid <= 1'b0;
      m_tx.o_tdata  <= '0;
      m_tx.o_tlast  <= 1'b0;
      m_tx.o_tsof   <= 1'b0;
      overflow      <= 1'b0;
      sync_err      <= 1'b0;
    end else begin
      if (accept_c) begin
        if (last_c) begin
          sig_cnt <= '0;
          if (sym_c == NSYMB_WIDTH'(NSYMB - 1)) begin
            state    <= IDLE;
            symb_idx <= '0;
          end else begin
            state    <= RUN;
            symb_idx <= sym_c + NSYMB_WIDTH'(1);
          end
        end else begin
          state    <= RUN;
          sig_cnt  <= pos_c + SIG_WIDTH'(1);
          symb_idx <= sym_c;
        end
      end

      wr_ptr <= wr_nxt_c;
      rd_ptr <= rd_nxt_c;

      if (wr_nxt_c != rd_nxt_c) begin
        m_tx.o_tvalid <= 1'b1;
        m_tx.o_tsof   <= head_c[EW-1];
        m_tx.o_tlast  <= head_c[EW-2];
        m_tx.o_tdata  <= head_c[DW2-1:0];
      end else begin
        m_tx.o_tvalid <= 1'b0;
        m_tx.o_tsof   <= 1'b0;
        m_tx.o_tlast  <= 1'b0;
      end

      overflow <= ovf_ev_c  || (overflow && !err_clr);
      sync_err <= sync_ev_c || (sync_err && !err_clr);
    end
  end
endmodule

// File: tb/tb_mtx_tx_framer.sv
// Scoreboard bench for mtx_tx_framer: a burst-level reference model predicts
// the output stream and flags; a monitor checks what the DUT presents.
module tb_mtx_tx_framer;
  localparam int DW    = 16;
  localparam int NSIG  = 4;
  localparam int NSYMB = 2;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  typedef struct packed {
    logic          sof;
    logic          last;
    logic [2*DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] itx = '0;
  logic [DW-1:0] qtx = '0;
  logic          tx_valid = 1'b0;
  logic          tx_trig = 1'b0;
  logic          err_clr = 1'b0;
  logic [15:0]   symb_idx;
  logic          busy;
  logic          overflow;
  logic          sync_err;

  mtx_tx_framer_if #(.DATA_WIDTH(DW)) bus ();

  mtx_tx_framer #(
    .DATA_WIDTH(DW), .NSIG(NSIG), .NSYMB(NSYMB),
    .SIG_WIDTH(24), .NSYMB_WIDTH(16), .FIFO_AW(AW)
  ) dut (
    .clk(clk), .reset(reset), .itx(itx), .qtx(qtx),
    .tx_valid(tx_valid), .tx_trig(tx_trig), .err_clr(err_clr),
    .m_tx(bus), .symb_idx(symb_idx), .busy(busy),
    .overflow(overflow), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  // Reference model state: burst position as a plain sample count.
  exp_t sb[$];
  bit   m_run = 0;
  int   m_k = 0;
  int   m_occ = 0;
  bit   m_ovf = 0;
  bit   m_serr = 0;
  bit   skip_mon = 1;
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // One clock of stimulus; checks the state left by the previous edge first.
  task automatic step(input logic v, input logic t, input logic [DW-1:0] i,
                      input logic [DW-1:0] q, input logic rdy, input logic clr);
    bit pop, push, acc, sof, lst, sev, oev;
    @(negedge clk);
    chk("busy", 64'(busy), 64'(m_run));
    chk("symb_idx", 64'(symb_idx), m_run ? 64'(m_k / NSIG) : 64'd0);
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("sync_err", 64'(sync_err), 64'(m_serr));
    chk("tvalid", 64'(bus.o_tvalid), 64'(m_occ > 0));
    if (m_occ == 0) begin
      chk("tlast_empty", 64'(bus.o_tlast), 64'd0);
      chk("tsof_empty", 64'(bus.o_tsof), 64'd0);
    end
    tx_valid = v; tx_trig = t; itx = i; qtx = q; bus.o_tready = rdy; err_clr = clr;

    pop = (m_occ > 0) && rdy;
    acc = 0; sof = 0; sev = 0; oev = 0; push = 0; lst = 0;
    if (v) begin
      if (t && (!m_run || (m_k % NSIG) != 0)) begin
        sev = m_run; m_run = 1; m_k = 0; acc = 1; sof = 1;
      end else if (m_run) begin
        acc = 1;
      end
    end
    if (acc) begin
      lst = ((m_k % NSIG) == NSIG - 1);
      if (m_occ < DEPTH || pop) begin
        push = 1;
        sb.push_back({sof, lst, i, q});
      end else begin
        oev = 1;
      end
      m_k++;
      if (m_k == NSIG * NSYMB) begin
        m_run = 0; m_k = 0;
      end
    end
    m_occ = m_occ - int'(pop) + int'(push);
    m_ovf = oev || (m_ovf && !clr);
    m_serr = sev || (m_serr && !clr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    skip_mon = 1; reset = 1; tx_valid = 0; tx_trig = 0; err_clr = 0; bus.o_tready = 1;
    m_run = 0; m_k = 0; m_occ = 0; m_ovf = 0; m_serr = 0; sb.delete();
    @(negedge clk);
    reset = 0; skip_mon = 0;
    chk("rst_tvalid", 64'(bus.o_tvalid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_symb", 64'(symb_idx), 64'd0);
    chk("rst_flags", 64'({overflow, sync_err}), 64'd0);
  endtask

  task automatic idle(input int n, input logic rdy);
    repeat (n) step(1'b0, 1'b0, DW'($urandom), DW'($urandom), rdy, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 64) begin
      step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
      n++;
    end
    idle(2, 1'b1);
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic burst(input int n, input int trig_at2, input int stall_lo, input int stall_hi);
    for (int k = 0; k < n; k++)
      step(1'b1, (k == 0) || (k == trig_at2), DW'(k), DW'(-k),
           !(k >= stall_lo && k < stall_hi), 1'b0);
  endtask

  // Monitor: between edges, compare the presented head with the scoreboard.
  logic            prev_stall = 0;
  logic [2*DW-1:0] prev_data;
  initial forever begin
    @(negedge clk); #3;
    if (skip_mon || reset) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) chk("hold_tdata", 64'(bus.o_tdata), 64'(prev_data));
      if (bus.o_tvalid) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 64'd1, 64'd0);
        end else begin
          chk("tdata", 64'(bus.o_tdata), 64'(sb[0].data));
          chk("tlast", 64'(bus.o_tlast), 64'(sb[0].last));
          chk("tsof", 64'(bus.o_tsof), 64'(sb[0].sof));
          if (bus.o_tready) void'(sb.pop_front());
        end
      end
      prev_stall = bus.o_tvalid && !bus.o_tready;
      prev_data  = bus.o_tdata;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.o_tready = 1'b1;
    do_reset();
    chk("rst_tdata", 64'(bus.o_tdata), 64'd0);

    // Nominal burst.
    burst(8, -1, 100, 100);
    drain();

    // Pre-trigger samples are dropped, then a nominal burst.
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, DW'(16'h0a0 + k), DW'(k), 1'b1, 1'b0);
    burst(8, -1, 100, 100);
    drain();

    // Backpressure for 8 cycles during the burst.
    burst(8, -1, 2, 10);
    idle(2, 1'b0);
    drain();

    // Overflow: two back-to-back bursts (16 samples) with no ready, then clear.
    burst(16, 8, 0, 16);
    idle(2, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    drain();

    // Mid-symbol trigger on the 3rd sample; err_clr in the same cycle loses.
    for (int k = 0; k < 10; k++)
      step(1'b1, (k == 0) || (k == 2), DW'(k), DW'(-k), 1'b1, k == 2);
    drain();
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
    idle(1, 1'b1);

    // Reset mid-burst with samples queued, then a nominal burst.
    burst(5, -1, 3, 100);
    do_reset();
    burst(8, -1, 100, 100);
    drain();

    // Randomised traffic with sparse triggers, backpressure and clears.
    for (int n = 0; n < 600; n++)
      step(($urandom % 4) != 0, ($urandom % 10) == 0, DW'($urandom), DW'($urandom),
           ($urandom % 3) != 0, ($urandom % 16) == 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
